// File: rtl/jtag_uart_responder_pkg.sv
// Shared constants and types for the JTAG UART responder.
// Holds the register addresses, field positions and DATA read word.
package jtag_uart_pkg;

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_CONTROL = 3'd4;

    localparam int RVALID_BIT = 15;
    localparam int RAVAIL_LSB = 16;
    localparam int WSPACE_LSB = 16;

    typedef struct packed {
        logic [15:0] ravail;
        logic        rvalid;
        logic [6:0]  zero;
        logic [7:0]  data;
    } data_word_t;

endpackage

// File: rtl/jtag_uart_responder_if.sv
// Avalon-MM bus bundle between the CPU-side master and the responder.
// Ports: address, writedata, write, read (master out); waitrequest, readdata (slave out).
interface jtag_uart_if;

    logic [2:0]  address;
    logic [31:0] writedata;
    logic        write;
    logic        read;
    logic        waitrequest;
    logic [31:0] readdata;

    modport master (
        output address, writedata, write, read,
        input  waitrequest, readdata
    );

    modport slave (
        input  address, writedata, write, read,
        output waitrequest, readdata
    );

endinterface

// File: rtl/jtag_uart_responder_byte_fifo.sv
// Circular byte FIFO with registered occupancy count.
// Ports: clock, reset, put/putData/canPut (write side), get/getData/canGet (read side), count.
module byte_fifo #(
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                put,
    input  logic [7:0]          putData,
    output logic                canPut,
    input  logic                get,
    output logic [7:0]          getData,
    output logic                canGet,
    output logic [DEPTH_LOG2:0] count
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
    localparam int CW = DEPTH_LOG2 + 1;
    localparam logic [DEPTH_LOG2:0] FULL = CW'(DEPTH);

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  push;
    logic                  pop;

    // Flags come from the registered count only, so a full FIFO
    // refuses a push even when a pop happens in the same cycle.
    assign canPut  = (count != FULL);
    assign canGet  = (count != '0);
    assign push    = put & canPut;
    assign pop     = get & canGet;
    assign getData = mem[rd_ptr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= putData;
    end

endmodule

// File: rtl/jtag_uart_responder.sv
// Avalon-MM slave modelling the JTAG UART DATA/CONTROL registers.
// Ports: clock, reset, bus (slave), rx_put/rx_putData/rx_canPut, tx_get/tx_getData/tx_canGet.
module jtag_uart_responder
    import jtag_uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = 6
) (
    input  logic        clock,
    input  logic        reset,
    jtag_uart_if.slave  bus,
    output logic        rx_canPut,
    input  logic [7:0]  rx_putData,
    input  logic        rx_put,
    output logic        tx_canGet,
    output logic [7:0]  tx_getData,
    input  logic        tx_get
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
    localparam int CW = DEPTH_LOG2 + 1;

    logic          ack_q;
    logic [31:0]   readdata_q;
    logic          commit;
    logic          do_write;
    logic          do_read;
    logic          tx_push;
    logic          rx_pop;
    logic          rx_canGet;
    logic [7:0]    rx_getData;
    logic [CW-1:0] rx_count;
    logic [CW-1:0] tx_count;
    logic          tx_canPut;
    logic [CW-1:0] rx_left;
    logic [CW-1:0] tx_free;
    data_word_t    dw;
    logic [31:0]   rd_next;

    // Stall depends only on the request lines and the FSM state.
    assign bus.waitrequest = (bus.read | bus.write) & ~ack_q;
    assign bus.readdata    = readdata_q;

    assign commit   = ~ack_q & (bus.read | bus.write);
    assign do_write = commit & bus.write;
    assign do_read  = commit & bus.read & ~bus.write;
    assign tx_push  = do_write && (bus.address == ADDR_DATA);
    assign rx_pop   = do_read && (bus.address == ADDR_DATA);

    always_comb begin
        rx_left   = rx_count - CW'(rx_canGet);
        tx_free   = CW'(DEPTH) - tx_count;
        dw        = '0;
        dw.ravail = 16'(rx_left);
        dw.rvalid = rx_canGet;
        dw.data   = rx_canGet ? rx_getData : 8'h00;
        rd_next   = '0;
        if (do_read) begin
            unique case (bus.address)
                ADDR_DATA:    rd_next = dw;
                ADDR_CONTROL: rd_next[WSPACE_LSB +: 16] = 16'(tx_free);
                default:      rd_next = '0;
            endcase
        end
    end

    // IDLE commits and moves to ACK; ACK always returns to IDLE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ack_q      <= 1'b0;
            readdata_q <= '0;
        end else begin
            ack_q      <= commit;
            readdata_q <= commit ? rd_next : '0;
        end
    end

    byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_rx (
        .clock   (clock),
        .reset   (reset),
        .put     (rx_put),
        .putData (rx_putData),
        .canPut  (rx_canPut),
        .get     (rx_pop),
        .getData (rx_getData),
        .canGet  (rx_canGet),
        .count   (rx_count)
    );

    byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_tx (
        .clock   (clock),
        .reset   (reset),
        .put     (tx_push),
        .putData (bus.writedata[7:0]),
        .canPut  (tx_canPut),
        .get     (tx_get),
        .getData (tx_getData),
        .canGet  (tx_canGet),
        .count   (tx_count)
    );

endmodule

// File: tb/tb_jtag_uart_responder.sv
// Scoreboard bench for jtag_uart_responder.
// Drives bus and host FIFO ports; monitors compare readdata and TX bytes.
module tb_jtag_uart_responder;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       rx_canPut;
    logic [7:0] rx_putData = '0;
    logic       rx_put = 1'b0;
    logic       tx_canGet;
    logic [7:0] tx_getData;
    logic       tx_get = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [31:0] rd_exp [$];
    logic [7:0]  tx_exp [$];

    jtag_uart_if bus ();

    jtag_uart_responder #(.DEPTH_LOG2(6)) dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus),
        .rx_canPut  (rx_canPut),
        .rx_putData (rx_putData),
        .rx_put     (rx_put),
        .tx_canGet  (tx_canGet),
        .tx_getData (tx_getData),
        .tx_get     (tx_get)
    );

    always #5 clock = ~clock;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    // Read-response monitor.
    always @(negedge clock) begin
        if (!reset && bus.read && !bus.write && !bus.waitrequest) begin
            if (rd_exp.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_read: got %h expected none", bus.readdata);
            end else begin
                chk("readdata", bus.readdata, rd_exp.pop_front());
            end
        end
    end

    // TX host-side monitor.
    always @(negedge clock) begin
        if (!reset && tx_get && tx_canGet) begin
            if (tx_exp.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_tx: got %h expected none", tx_getData);
            end else begin
                chk("tx_byte", {24'h0, tx_getData}, {24'h0, tx_exp.pop_front()});
            end
        end
    end

    task automatic wait_ack();
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (bus.waitrequest && n < 8);
        if (bus.waitrequest) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: got waitrequest=1 expected 0");
        end
    endtask

    // Called just after a rising edge; returns just after a rising edge.
    task automatic xfer(input logic wr, input logic [2:0] a,
                        input logic [31:0] wd, input logic [31:0] e);
        if (!wr) rd_exp.push_back(e);
        bus.address   = a;
        bus.writedata = wd;
        bus.write     = wr;
        bus.read      = !wr;
        wait_ack();
        @(posedge clock);
        #1;
        bus.read  = 1'b0;
        bus.write = 1'b0;
    endtask

    task automatic host_put(input logic [7:0] d);
        rx_putData = d;
        rx_put     = 1'b1;
        @(posedge clock);
        #1;
        rx_put = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] pat;
        bus.address   = '0;
        bus.writedata = '0;
        bus.write     = 1'b0;
        bus.read      = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_waitrequest", {31'h0, bus.waitrequest}, 32'h0);
        chk("rst_readdata", bus.readdata, 32'h0);
        chk("rst_rx_canPut", {31'h0, rx_canPut}, 32'h1);
        chk("rst_tx_canGet", {31'h0, tx_canGet}, 32'h0);
        reset = 1'b0;
        @(posedge clock);
        #1;

        xfer(1'b0, 3'd4, 32'h0, 32'h0040_0000);
        xfer(1'b0, 3'd0, 32'h0, 32'h0000_0000);
        xfer(1'b0, 3'd2, 32'h0, 32'h0000_0000);

        host_put(8'h41);
        host_put(8'h42);
        xfer(1'b0, 3'd0, 32'h0, 32'h0001_8041);
        xfer(1'b0, 3'd0, 32'h0, 32'h0000_8042);
        xfer(1'b0, 3'd0, 32'h0, 32'h0000_0000);

        for (int i = 0; i < 65; i++) begin
            if (i < 64) tx_exp.push_back(8'(i));
            xfer(1'b1, 3'd0, 32'(i), 32'h0);
            if (i == 0) chk("tx_canGet_rise", {31'h0, tx_canGet}, 32'h1);
        end
        xfer(1'b1, 3'd4, 32'h55, 32'h0);
        xfer(1'b0, 3'd4, 32'h0, 32'h0000_0000);
        tx_get = 1'b1;
        repeat (64) @(posedge clock);
        #1;
        tx_get = 1'b0;
        chk("tx_canGet_fall", {31'h0, tx_canGet}, 32'h0);
        chk("tx_drained", tx_exp.size(), 32'h0);

        rx_put = 1'b1;
        for (int j = 0; j < 64; j++) begin
            rx_putData = 8'(j);
            @(posedge clock);
            #1;
        end
        rx_put = 1'b0;
        chk("rx_full", {31'h0, rx_canPut}, 32'h0);
        host_put(8'hEE);

        rd_exp.push_back(32'h003F_8000);
        bus.address = 3'd0;
        bus.read    = 1'b1;
        rx_putData  = 8'h77;
        rx_put      = 1'b1;
        @(posedge clock);
        #1;
        rx_put = 1'b0;
        chk("rx_count63", {31'h0, rx_canPut}, 32'h1);
        @(posedge clock);
        #1;
        bus.read = 1'b0;
        for (int j = 1; j < 64; j++)
            xfer(1'b0, 3'd0, 32'h0, {16'(63 - j), 8'h80, 8'(j)});
        xfer(1'b0, 3'd0, 32'h0, 32'h0000_0000);

        host_put(8'h10);
        host_put(8'h11);
        host_put(8'h12);
        rd_exp.push_back(32'h0002_8010);
        rd_exp.push_back(32'h0001_8011);
        pat = '0;
        bus.address = 3'd0;
        bus.read    = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            pat = {pat[2:0], bus.waitrequest};
        end
        @(posedge clock);
        #1;
        bus.read = 1'b0;
        chk("b2b_pattern", {28'h0, pat}, 32'h0000_000A);
        xfer(1'b0, 3'd0, 32'h0, 32'h0000_8012);
        xfer(1'b0, 3'd0, 32'h0, 32'h0000_0000);

        bus.address   = 3'd0;
        bus.writedata = 32'h99;
        bus.write     = 1'b1;
        @(negedge clock);
        chk("wr_stall", {31'h0, bus.waitrequest}, 32'h1);
        #1;
        reset     = 1'b1;
        bus.write = 1'b0;
        #1;
        chk("rst_mid_wait", {31'h0, bus.waitrequest}, 32'h0);
        chk("rst_mid_tx", {31'h0, tx_canGet}, 32'h0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
        chk("post_rst_tx", {31'h0, tx_canGet}, 32'h0);
        xfer(1'b0, 3'd4, 32'h0, 32'h0040_0000);

        @(posedge clock);
        #1;
        chk("rd_queue_empty", rd_exp.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jtag_uart_responder.md
# jtag_uart_responder

Avalon memory-mapped slave that models the JTAG UART register interface for simulation and loopback testing. It stands on the device side of the bus that the JTAGUART master drives, so the CPU top level can run without the vendor IP. Two byte FIFOs connect it to a host-side testbench or stream source:

- RX: host to CPU, drained by reads of the data register.
- TX: CPU to host, filled by writes to the data register.

## Interface
Parameters:
- `DEPTH_LOG2`, default 6. Each FIFO holds 2^DEPTH_LOG2 bytes; legal range 1..15.

Ports (one clock; reset is asynchronous and active-high):
- `clock`  in  1  sole clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `address`  in  3  Avalon byte address: 0 = DATA, 4 = CONTROL, others unmapped
- `writedata`  in  32  write data
- `write`  in  1  write request, held until `waitrequest` is low
- `read`  in  1  read request, held until `waitrequest` is low
- `waitrequest`  out  1  stall; low for exactly the completing cycle
- `readdata`  out  32  read data, valid when `read` is high and `waitrequest` is low
- `rx_canPut`  out  1  RX FIFO not full
- `rx_putData`  in  8  host byte to enqueue
- `rx_put`  in  1  enqueue `rx_putData`; ignored when `rx_canPut` is low
- `tx_canGet`  out  1  TX FIFO not empty
- `tx_getData`  out  8  TX head byte, valid while `tx_canGet` is high
- `tx_get`  in  1  dequeue TX head; ignored when `tx_canGet` is low

## Operation
- Register map:
  - DATA read: `[7:0]` RX head byte (0 if empty); `[15]` RVALID (1 if a byte was returned); `[31:16]` RAVAIL, the RX count after the pop, zero-extended; other bits 0.
  - DATA write: enqueue `writedata[7:0]` into TX. If TX is full the byte is silently dropped; no error and no stall.
  - CONTROL read: `[31:16]` WSPACE, the TX free count zero-extended; other bits 0. CONTROL write: no effect.
  - Unmapped address: read returns 0; write has no effect.
- Transaction FSM, state held in `ack_q`:
  - IDLE (`ack_q`=0): `read` or `write` high gives `waitrequest`=1 combinationally. At the edge, commit the side effect (RX pop or TX push), register `readdata`, and go to ACK.
  - ACK (`ack_q`=1): `waitrequest`=0 and `readdata` is presented. Return to IDLE unconditionally at the next edge.
  - Each transaction therefore takes exactly 2 cycles and commits exactly once. Back-to-back requests alternate IDLE/ACK.
  - `read` and `write` both high: `write` takes precedence; `readdata` is 0.
- FIFOs:
  - Circular, with DEPTH_LOG2-bit pointers that wrap naturally and a (DEPTH_LOG2+1)-bit count.
  - `canPut` and `canGet` derive from registered count only. A push to a full FIFO is refused even if a pop happens in the same cycle.
  - Simultaneous push and pop on a non-full, non-empty FIFO leave the count unchanged.
  - RX pop (bus) and host `rx_put` may coincide. TX push (bus) and host `tx_get` may coincide.

## Timing
- Reset values: `waitrequest`=0, `readdata`=0, `ack_q`=0, both FIFOs empty, `rx_canPut`=1, `tx_canGet`=0. `tx_getData` is don't-care while empty.
- Bus read latency: 2 cycles from request assertion to the sampled `readdata`.
- Host FIFO latency: a byte pushed at edge N is visible to the other side after edge N.
  - `tx_canGet` rises the cycle after the bus commit edge.
  - RVALID reflects a host `rx_put` at edge N for any bus commit at edge N+1 or later.
- Reset asserted mid-transaction forces IDLE and empties both FIFOs immediately.
  - The master must re-issue; the aborted transaction has no committed side effect unless its commit edge preceded reset.
- `waitrequest` is a combinational function of `read`, `write` and `ack_q` only, with no path from the FIFOs.

## Structure
- Shared package `jtag_uart_pkg` holds:
  - `ADDR_DATA`=3'd0 and `ADDR_CONTROL`=3'd4
  - bit-position constants for RVALID, RAVAIL and WSPACE
  - a packed typedef for the DATA read word
- One sub-module, `byte_fifo #(DEPTH_LOG2)`, with ports `clock`, `reset`, `put`, `putData`, `canPut`, `get`, `getData`, `canGet` and `count`. It is instantiated twice, once for RX and once for TX.

## Test plan
- Reset, then read CONTROL: response after 2 cycles equals 0x0040_0000 (WSPACE=64); a DATA read returns 0x0000_0000.
- Host puts 0x41 and 0x42, then two DATA reads: first returns 0x0001_8041, second 0x0000_8042, a third returns 0x0000_0000.
- 65 DATA writes of 0x00..0x40: the 65th byte is dropped. CONTROL then reads 0x0000_0000, and host drains 0x00..0x3F in order with `tx_canGet` falling after the 64th.
- Host fills RX to 64 entries: `rx_canPut`=0 and an extra `rx_put` is ignored. A bus pop with a host put in the same cycle keeps count at 63 until the next edge.
- Back-to-back reads with `read` held high for 4 cycles: `waitrequest` pattern 1,0,1,0 and exactly two pops.
- Assert reset during a write's IDLE cycle: no TX entry, `waitrequest`=0, and CONTROL reads WSPACE=64 afterwards.
